// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_issue_ctrl                                               |
// | Description : Single-outstanding issue sequencer between the integer       |
// |               pipeline and the FP arithmetic unit. Registers one request,  |
// |               holds start until done (or timeout), returns the result on   |
// |               a valid/ready response port and keeps sticky fflags.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fpu_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [2:0]       req_rm,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_rs2_lsb,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             fpu_start,
  output logic [4:0]       fpu_op,
  output logic [2:0]       fpu_rm,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic             fpu_rs2_lsb,
  input  logic [31:0]      fpu_out,
  input  logic             fpu_done,
  input  logic             fpu_nv,
  input  logic             fpu_dz,
  input  logic             fpu_of,
  input  logic             fpu_uf,
  input  logic             fpu_nx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       rsp_flags,
  output logic             rsp_err,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr,
  output logic             busy
);

  // Counter only needs to reach TIMEOUT-1, the last EXEC cycle before forced error.
  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_alive;
  logic [CNT_W-1:0]   r_cnt;

  logic [4:0]         r_op;
  logic [2:0]         r_rm;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_rs2_lsb;
  logic [TAG_W-1:0]   r_tag;

  logic [31:0]        r_data;
  logic [4:0]         r_flags;
  logic               r_err;
  logic [4:0]         r_acc;

  logic               w_accept;
  logic               w_done;
  logic               w_timeout;
  logic               w_rsp_hs;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Ready is withheld until the first clock edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_alive <= 1'b0;
    else       r_alive <= 1'b1;
  end

  // Next-state and handshake decode; flush overrides every other event.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_hs    = 1'b0;
    req_ready   = 1'b0;
    fpu_start   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = r_alive & ~flush;
        w_accept  = r_alive & ~flush & req_valid;
        if (w_accept) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        fpu_start = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (fpu_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == C_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // EXEC cycle counter, zeroed on accept so the first EXEC cycle reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (w_accept)         r_cnt <= '0;
    else if (r_state == S_EXEC) r_cnt <= r_cnt + 1'b1;
  end

  // Request operand registers; held stable for the whole EXEC/RESP period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_rm      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rs2_lsb <= 1'b0;
      r_tag     <= '0;
    end else if (w_accept) begin
      r_op      <= req_op;
      r_rm      <= req_rm;
      r_a       <= req_a;
      r_b       <= req_b;
      r_rs2_lsb <= req_rs2_lsb;
      r_tag     <= req_tag;
    end
  end

  // Result capture: unit result on done, zeroed error response on timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else if (w_done) begin
      r_data  <= fpu_out;
      r_flags <= {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
      r_err   <= 1'b0;
    end else if (w_timeout) begin
      r_data  <= '0;
      r_flags <= '0;
      r_err   <= 1'b1;
    end
  end

  // Sticky flags commit only on the response handshake; clear may combine with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_acc <= '0;
    else if (w_rsp_hs)   r_acc <= (fflags_clr ? 5'd0 : r_acc) | (r_err ? 5'd0 : r_flags);
    else if (fflags_clr) r_acc <= '0;
  end

  assign fpu_op      = r_op;
  assign fpu_rm      = r_rm;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;
  assign fpu_rs2_lsb = r_rs2_lsb;
  assign rsp_data    = r_data;
  assign rsp_tag     = r_tag;
  assign rsp_flags   = r_flags;
  assign rsp_err     = r_err;
  assign fflags_acc  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fpu_issue_ctrl                                            |
// | Description : Self-checking bench for fpu_issue_ctrl with a cycle-level    |
// |               FP unit stand-in and a transaction-level expectation model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fpu_issue_ctrl;

  localparam int TMO   = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [4:0]       req_op;
  logic [2:0]       req_rm;
  logic [31:0]      req_a, req_b;
  logic             req_rs2_lsb;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             fpu_start;
  logic [4:0]       fpu_op;
  logic [2:0]       fpu_rm;
  logic [31:0]      fpu_a, fpu_b;
  logic             fpu_rs2_lsb;
  logic [31:0]      fpu_out;
  logic             fpu_done;
  logic             fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [4:0]       rsp_flags;
  logic             rsp_err;
  logic [4:0]       fflags_acc;
  logic             fflags_clr;
  logic             busy;

  fpu_issue_ctrl #(.TIMEOUT(TMO), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_rs2_lsb(req_rs2_lsb), .req_tag(req_tag),
    .flush(flush),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_out(fpu_out), .fpu_done(fpu_done),
    .fpu_nv(fpu_nv), .fpu_dz(fpu_dz), .fpu_of(fpu_of), .fpu_uf(fpu_uf), .fpu_nx(fpu_nx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .fflags_acc(fflags_acc),
    .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] m_acc  = 5'd0;

  // Observations gathered by the transaction driver.
  logic             obs_ready;
  logic [4:0]       obs_op;
  logic [2:0]       obs_rm;
  logic [31:0]      obs_a, obs_b;
  logic             obs_rs2;
  int               obs_start, obs_lat, obs_unstable;
  logic [31:0]      obs_data;
  logic [TAG_W-1:0] obs_tag;
  logic [4:0]       obs_flags;
  logic             obs_err;
  logic [4:0]       obs_acc_pre, obs_acc_post;
  logic             obs_ready_post, obs_valid_post, obs_busy_post, obs_start_post;

  // Issues one op, emulates the unit (done on the lat-th start cycle, never when
  // lat==0), consumes the response after rdy_delay cycles, optional flush cycle.
  task automatic do_op(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic rs2, input logic [TAG_W-1:0] tag,
                       input int lat, input logic [31:0] res, input logic [4:0] flg,
                       input int rdy_delay, input int flush_at, input bit clr_hs);
    int sc, rc;
    bit fin;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b;
    req_rs2_lsb = rs2; req_tag = tag;
    flush = 1'b0; rsp_ready = 1'b0; fflags_clr = 1'b0; fpu_done = 1'b0;
    #1 obs_ready = req_ready;
    sc = 0; rc = 0; fin = 1'b0; obs_lat = -1; obs_unstable = 0;
    obs_op = '0; obs_rm = '0; obs_a = '0; obs_b = '0; obs_rs2 = 1'b0;
    obs_data = '0; obs_tag = '0; obs_flags = '0; obs_err = 1'b0; obs_acc_pre = '0;
    for (int cyc = 1; cyc <= TMO + 20 && !fin; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; req_op = 5'($urandom); req_rm = 3'($urandom);
      req_a = $urandom; req_b = $urandom; req_rs2_lsb = 1'($urandom); req_tag = TAG_W'($urandom);
      flush = (cyc == flush_at); rsp_ready = 1'b0; fflags_clr = 1'b0;
      fpu_done = 1'($urandom_range(0, 1)); fpu_out = $urandom;
      {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = 5'($urandom);
      #1;
      if (fpu_start === 1'b1) begin
        sc++;
        if (sc == 1) begin
          obs_op = fpu_op; obs_rm = fpu_rm; obs_a = fpu_a; obs_b = fpu_b; obs_rs2 = fpu_rs2_lsb;
        end else if ({fpu_op, fpu_rm, fpu_a, fpu_b, fpu_rs2_lsb} !== {obs_op, obs_rm, obs_a, obs_b, obs_rs2})
          obs_unstable++;
        fpu_done = (sc == lat);
        if (sc == lat) begin
          fpu_out = res;
          {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = flg;
        end
      end
      if (rsp_valid === 1'b1) begin
        if (rc == 0) begin
          obs_lat = cyc; obs_data = rsp_data; obs_tag = rsp_tag; obs_flags = rsp_flags;
          obs_err = rsp_err; obs_acc_pre = fflags_acc;
        end else if ({rsp_data, rsp_tag, rsp_flags, rsp_err} !== {obs_data, obs_tag, obs_flags, obs_err})
          obs_unstable++;
        if (req_ready !== 1'b0 || fpu_start !== 1'b0) obs_unstable++;
        if (cyc == flush_at) rsp_ready = 1'b1;
        else if (rc == rdy_delay) begin
          rsp_ready = 1'b1; fflags_clr = clr_hs; fin = 1'b1;
        end
        rc++;
      end
      if (cyc == flush_at) fin = 1'b1;
    end
    obs_start = sc;
    @(negedge clk);
    flush = 1'b0; rsp_ready = 1'b0; fflags_clr = 1'b0; fpu_done = 1'b0;
    #1;
    obs_acc_post = fflags_acc; obs_ready_post = req_ready; obs_valid_post = rsp_valid;
    obs_busy_post = busy; obs_start_post = fpu_start;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    req_rs2_lsb = 1'b0; req_tag = '0; flush = 1'b0; fpu_out = '0; fpu_done = 1'b0;
    {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = '0; rsp_ready = 1'b0; fflags_clr = 1'b0;
    #12;
    checks++;
    if ({req_ready, busy, fpu_start, rsp_valid, rsp_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {req_ready, busy, fpu_start, rsp_valid, rsp_err});
    end
    checks++;
    if ({fpu_a, fpu_b, rsp_data, fflags_acc, rsp_flags, rsp_tag} !== '0) begin
      errors++; $display("FAIL reset_data got nonzero a=%h data=%h acc=%b", fpu_a, rsp_data, fflags_acc);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early got %b exp 0", req_ready); end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_late got %b exp 1", req_ready); end
  endtask

  task automatic test_fadd;
    do_op(5'b00000, 3'b000, 32'h3F800000, 32'h40000000, 1'b0, 5'd5, 1, 32'h40400000, 5'b00000, 0, 0, 1'b0);
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL fadd_accept got %b exp 1", obs_ready); end
    checks++;
    if ({obs_op, obs_a, obs_b} !== {5'b00000, 32'h3F800000, 32'h40000000}) begin
      errors++; $display("FAIL fadd_operands got op=%b a=%h b=%h", obs_op, obs_a, obs_b);
    end
    checks++;
    if (obs_lat != 2) begin errors++; $display("FAIL fadd_latency got %0d exp 2", obs_lat); end
    checks++;
    if ({obs_data, obs_flags, obs_err, obs_tag} !== {32'h40400000, 5'b00000, 1'b0, 5'd5}) begin
      errors++; $display("FAIL fadd_rsp got data=%h flags=%b err=%b tag=%0d exp 40400000/00000/0/5",
                         obs_data, obs_flags, obs_err, obs_tag);
    end
    checks++;
    if (obs_ready_post !== 1'b1 || obs_acc_post !== m_acc) begin
      errors++; $display("FAIL fadd_post got ready=%b acc=%b exp 1/%b", obs_ready_post, obs_acc_post, m_acc);
    end
  endtask

  task automatic test_fdiv;
    do_op(5'b00011, 3'b111, 32'h3F800000, 32'h00000000, 1'b0, 5'd9, 12, 32'h7F800000, 5'b01000, 0, 0, 1'b0);
    m_acc = m_acc | 5'b01000;
    checks++;
    if (obs_start != 12) begin errors++; $display("FAIL fdiv_start_cycles got %0d exp 12", obs_start); end
    checks++;
    if (obs_lat != 13) begin errors++; $display("FAIL fdiv_latency got %0d exp 13", obs_lat); end
    checks++;
    if (obs_flags !== 5'b01000 || obs_rm !== 3'b111) begin
      errors++; $display("FAIL fdiv_flags got flags=%b rm=%b exp 01000/111", obs_flags, obs_rm);
    end
    checks++;
    if (obs_acc_pre !== 5'b00000) begin errors++; $display("FAIL fdiv_acc_pre got %b exp 00000", obs_acc_pre); end
    checks++;
    if (obs_acc_post !== 5'b01000) begin errors++; $display("FAIL fdiv_acc_post got %b exp 01000", obs_acc_post); end
  endtask

  task automatic test_stall;
    do_op(5'b00001, 3'b001, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5'd17, 3, 32'hCAFEF00D, 5'b00100, 5, 0, 1'b0);
    m_acc = m_acc | 5'b00100;
    checks++;
    if (obs_unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", obs_unstable); end
    checks++;
    if (obs_lat != 4 || obs_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL stall_rsp got lat=%0d data=%h exp 4/cafef00d", obs_lat, obs_data);
    end
    checks++;
    if (obs_acc_post !== m_acc || obs_ready_post !== 1'b1) begin
      errors++; $display("FAIL stall_post got acc=%b ready=%b exp %b/1", obs_acc_post, obs_ready_post, m_acc);
    end
    do_op(5'b00000, 3'b000, 32'h1, 32'h2, 1'b0, 5'd3, 1, 32'h3, 5'b00000, 0, 0, 1'b0);
    checks++;
    if (obs_ready !== 1'b1 || obs_lat != 2) begin
      errors++; $display("FAIL stall_next_accept got ready=%b lat=%0d exp 1/2", obs_ready, obs_lat);
    end
  endtask

  task automatic test_flush_exec;
    do_op(5'b00010, 3'b000, 32'h40400000, 32'h40800000, 1'b0, 5'd2, 10, 32'h41400000, 5'b00001, 0, 3, 1'b0);
    checks++;
    if (obs_lat != -1 || obs_start != 3) begin
      errors++; $display("FAIL flush_exec got rsp_at=%0d start=%0d exp -1/3", obs_lat, obs_start);
    end
    checks++;
    if ({obs_ready_post, obs_busy_post, obs_start_post, obs_valid_post} !== 4'b1000 || obs_acc_post !== m_acc) begin
      errors++; $display("FAIL flush_exec_post got rdy/busy/start/valid=%b acc=%b exp 1000/%b",
                         {obs_ready_post, obs_busy_post, obs_start_post, obs_valid_post}, obs_acc_post, m_acc);
    end
  endtask

  task automatic test_flush_resp;
    // RESP starts at cycle 3; flush on cycle 4 while rsp_ready is also high.
    do_op(5'b00000, 3'b000, 32'h5, 32'h6, 1'b0, 5'd4, 2, 32'h7, 5'b00010, 3, 4, 1'b0);
    checks++;
    if (obs_lat != 3 || obs_valid_post !== 1'b0 || obs_acc_post !== m_acc) begin
      errors++; $display("FAIL flush_resp got lat=%0d valid=%b acc=%b exp 3/0/%b",
                         obs_lat, obs_valid_post, obs_acc_post, m_acc);
    end
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %b exp 0", req_ready); end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_accept got busy=%b ready=%b exp 0/1", busy, req_ready);
    end
  endtask

  task automatic test_timeout;
    do_op(5'b00011, 3'b000, 32'h1, 32'h2, 1'b0, 5'd11, 0, 32'hFFFFFFFF, 5'b11111, 0, 0, 1'b0);
    checks++;
    if (obs_start != TMO || obs_lat != TMO + 1) begin
      errors++; $display("FAIL timeout_len got start=%0d rsp_at=%0d exp %0d/%0d", obs_start, obs_lat, TMO, TMO + 1);
    end
    checks++;
    if ({obs_err, obs_data, obs_flags} !== {1'b1, 32'h0, 5'b0}) begin
      errors++; $display("FAIL timeout_rsp got err=%b data=%h flags=%b exp 1/0/0", obs_err, obs_data, obs_flags);
    end
    checks++;
    if (obs_acc_post !== m_acc) begin errors++; $display("FAIL timeout_acc got %b exp %b", obs_acc_post, m_acc); end
  endtask

  task automatic test_clr_idle;
    @(negedge clk); fflags_clr = 1'b1;
    @(negedge clk); fflags_clr = 1'b0;
    #1;
    m_acc = 5'b0;
    checks++;
    if (fflags_acc !== 5'b0) begin errors++; $display("FAIL clr_idle got %b exp 00000", fflags_acc); end
  endtask

  task automatic test_clr_hs;
    do_op(5'b00000, 3'b000, 32'h1, 32'h1, 1'b0, 5'd1, 2, 32'h2, 5'b10000, 0, 0, 1'b0);
    checks++;
    if (obs_acc_post !== 5'b10000) begin errors++; $display("FAIL clr_hs_pre got %b exp 10000", obs_acc_post); end
    do_op(5'b00000, 3'b000, 32'h1, 32'h1, 1'b0, 5'd1, 1, 32'h2, 5'b00001, 1, 0, 1'b1);
    m_acc = 5'b00001;
    checks++;
    if (obs_acc_post !== 5'b00001) begin errors++; $display("FAIL clr_hs got %b exp 00001", obs_acc_post); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0; fpu_done = 1'b0;
    #1;
    checks++;
    if (fpu_start !== 1'b1) begin errors++; $display("FAIL areset_pre got start=%b exp 1", fpu_start); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({fpu_start, busy, rsp_valid, req_ready} !== 4'b0 || fflags_acc !== 5'b0 || fpu_a !== 32'h0) begin
      errors++; $display("FAIL areset_now got start/busy/valid/ready=%b acc=%b a=%h exp 0000/00000/0",
                         {fpu_start, busy, rsp_valid, req_ready}, fflags_acc, fpu_a);
    end
    m_acc = 5'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_release got ready=%b busy=%b exp 1/0", req_ready, busy);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [31:0]      a, b, res;
      logic [4:0]       op, flg;
      logic [TAG_W-1:0] tag;
      int               lat, rdy, fl, exec_len, e_start, e_lat;
      bit               clr, e_err, fl_exec, fl_resp;
      a = $urandom; b = $urandom; res = $urandom; op = 5'($urandom); flg = 5'($urandom);
      tag = TAG_W'($urandom); clr = ($urandom_range(0, 3) == 0);
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      rdy = $urandom_range(0, 3);
      e_err    = !(lat >= 1 && lat <= TMO);
      exec_len = e_err ? TMO : lat;
      fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, exec_len + 1 + rdy)) : 0;
      fl_exec = (fl >= 1 && fl <= exec_len);
      fl_resp = (fl > exec_len);
      e_start = fl_exec ? fl : exec_len;
      e_lat   = fl_exec ? -1 : exec_len + 1;
      if (!fl_exec && !fl_resp) m_acc = (clr ? 5'b0 : m_acc) | (e_err ? 5'b0 : flg);
      do_op(op, 3'($urandom), a, b, 1'($urandom), tag, lat, res, flg, rdy, fl, clr);
      checks++;
      if (obs_ready !== 1'b1 || obs_a !== a || obs_b !== b || obs_op !== op) begin
        errors++; $display("FAIL rnd%0d_issue got ready=%b a=%h b=%h op=%b exp 1/%h/%h/%b",
                           n, obs_ready, obs_a, obs_b, obs_op, a, b, op);
      end
      checks++;
      if (obs_start != e_start || obs_lat != e_lat) begin
        errors++; $display("FAIL rnd%0d_timing got start=%0d rsp_at=%0d exp %0d/%0d",
                           n, obs_start, obs_lat, e_start, e_lat);
      end
      if (e_lat != -1) begin
        checks++;
        if ({obs_err, obs_data, obs_flags, obs_tag} !== {e_err, (e_err ? 32'h0 : res), (e_err ? 5'b0 : flg), tag}
            || obs_unstable != 0) begin
          errors++; $display("FAIL rnd%0d_rsp got err=%b data=%h flags=%b tag=%0d unstable=%0d exp %b/%h/%b/%0d/0",
                             n, obs_err, obs_data, obs_flags, obs_tag, obs_unstable,
                             e_err, (e_err ? 32'h0 : res), (e_err ? 5'b0 : flg), tag);
        end
      end
      checks++;
      if (obs_acc_post !== m_acc || obs_ready_post !== 1'b1 || obs_valid_post !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_post got acc=%b ready=%b valid=%b exp %b/1/0",
                           n, obs_acc_post, obs_ready_post, obs_valid_post, m_acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fdiv();
    test_stall();
    test_flush_exec();
    test_flush_resp();
    test_flush_idle();
    test_timeout();
    test_clr_idle();
    test_clr_hs();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
